// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes ahead of IP into a small FIFO,
// hands them to the decoder one per handshake and pulses ip_inc per byte.
// A flush discards queued bytes and any in-flight fetch, then restarts at flush_addr.
module prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_addr,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic                     mem_ack,
  input  logic [7:0]               mem_rdata,
  output logic                     q_valid,
  output logic [7:0]               q_data,
  input  logic                     q_ready,
  output logic                     ip_inc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_n;
  logic [AW-1:0]   fetch_addr_r, fetch_addr_n;
  logic            mem_req_r, mem_req_n;
  logic [AW-1:0]   mem_addr_r, mem_addr_n;
  logic [7:0]      fifo_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push, pop;

  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;
  assign q_count  = count_r;
  assign q_valid  = (count_r != {CW{1'b0}});
  // A flush cycle never consumes a byte, so IP does not advance either.
  assign pop      = q_valid & q_ready & ~flush;
  assign ip_inc   = pop;

  // Head byte presented to the decoder; forced to zero when the queue is empty.
  always_comb begin
    q_data = 8'h00;
    if (q_valid) begin
      q_data = fifo_r[rd_ptr_r];
    end else begin
      q_data = 8'h00;
    end
  end

  // Fetch FSM: issue one request at a time, hold it until acked, drop stale data after a flush.
  always_comb begin
    state_n      = state_r;
    fetch_addr_n = fetch_addr_r;
    mem_req_n    = mem_req_r;
    mem_addr_n   = mem_addr_r;
    push         = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          fetch_addr_n = flush_addr;
        end else if (count_r < DEPTH_C) begin
          // Issuing only below DEPTH reserves a slot for the returning byte.
          mem_addr_n = fetch_addr_r;
          mem_req_n  = 1'b1;
          state_n    = REQ;
        end else begin
          mem_req_n = 1'b0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          state_n   = IDLE;
          if (flush) begin
            fetch_addr_n = flush_addr;
          end else begin
            push         = 1'b1;
            fetch_addr_n = fetch_addr_r + AW'(1);
          end
        end else if (flush) begin
          // The bus request cannot be withdrawn; wait it out in DRAIN.
          fetch_addr_n = flush_addr;
          state_n      = DRAIN;
        end else begin
          state_n = REQ;
        end
      end
      DRAIN: begin
        if (flush) begin
          fetch_addr_n = flush_addr;
        end else begin
          fetch_addr_n = fetch_addr_r;
        end
        if (mem_ack) begin
          mem_req_n = 1'b0;
          state_n   = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  // Fetch FSM state, fetch pointer and bus request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      fetch_addr_r <= {AW{1'b0}};
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
    end else begin
      state_r      <= state_n;
      fetch_addr_r <= fetch_addr_n;
      mem_req_r    <= mem_req_n;
      mem_addr_r   <= mem_addr_n;
    end
  end

  // Byte FIFO storage, pointers and occupancy; flush empties it in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= 8'h00;
      end
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        fifo_r[wr_ptr_r] <= mem_rdata;
        wr_ptr_r         <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized scoreboard bench for prefetch_queue. The reference model tracks the
// byte stream the decoder must see: consecutive addresses from the last flush
// target (0 after reset), each byte equal to addr ^ 8'hA5.
module tb_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic [AW-1:0]         flush_addr = 8'h00;
  logic                  mem_req;
  logic [AW-1:0]         mem_addr;
  logic                  mem_ack = 1'b0;
  logic [7:0]            mem_rdata = 8'h00;
  logic                  q_valid;
  logic [7:0]            q_data;
  logic                  q_ready = 1'b0;
  logic                  ip_inc;
  logic [$clog2(DEPTH):0] q_count;

  int vectors = 0;
  int miscompares = 0;

  prefetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .q_valid(q_valid), .q_data(q_data), .q_ready(q_ready), .ip_inc(ip_inc),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks 0..3 cycles into a request, data = addr ^ A5; stray acks when idle.
  initial begin
    int wait_cnt;
    wait_cnt = 1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_ack  = 1'b0;
        wait_cnt = 1;
      end else if (mem_req) begin
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ 8'hA5;
          wait_cnt  = $urandom_range(0, 3);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'($urandom);
          wait_cnt--;
        end
      end else begin
        mem_ack   = ($urandom_range(0, 9) == 0);
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Scoreboard / monitor state.
  byte unsigned  sb[$];
  logic [AW-1:0] exp_fetch = 8'h00;
  logic          tainted   = 1'b0;
  logic          prev_req  = 1'b0;
  logic [AW-1:0] prev_addr = 8'h00;

  // Monitor: sampled on the falling edge, compares DUT outputs against the model.
  initial begin
    logic exp_pop;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        exp_fetch = 8'h00;
        tainted   = 1'b0;
        prev_req  = 1'b0;
      end else begin
        chk("q_count", 32'(q_count), 32'(sb.size()));
        chk("q_valid", 32'(q_valid), 32'(sb.size() != 0));
        chk("q_data", 32'(q_data), (sb.size() != 0) ? 32'(sb[0]) : 32'h0);
        exp_pop = (sb.size() != 0) && q_ready && !flush;
        chk("ip_inc", 32'(ip_inc), 32'(exp_pop));
        if (mem_req) begin
          if (!prev_req) begin
            chk("req_addr", 32'(mem_addr), 32'(exp_fetch));
            tainted = 1'b0;
          end else begin
            chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
          end
        end
        if (flush) begin
          if (mem_req && !mem_ack) tainted = 1'b1;
          exp_fetch = flush_addr;
          sb.delete();
        end else begin
          if (exp_pop) void'(sb.pop_front());
          if (mem_req && mem_ack && !tainted) begin
            sb.push_back(mem_addr ^ 8'hA5);
            exp_fetch = mem_addr + 8'h01;
          end
        end
        prev_req  = mem_req && !mem_ack;
        prev_addr = mem_addr;
      end
    end
  end

  // Stimulus: directed phases from the test plan, then randomized traffic.
  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fill with decoder stalled: four bytes from 00, fetching stops.
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("fill_count", 32'(q_count), 32'd4);
    chk("fill_req", 32'(mem_req), 32'd0);
    chk("fill_data", 32'(q_data), 32'hA5);

    // Drain continuously; the scoreboard checks the byte stream.
    @(posedge clk); #1 q_ready = 1'b1;
    repeat (40) @(posedge clk);

    // Flush coinciding with a ready head byte: no ip_inc, queue empties.
    #1 q_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      #1 seen = q_valid;
    end
    chk("wait_valid", 32'(seen), 32'd1);
    flush = 1'b1; flush_addr = 8'hFF; q_ready = 1'b1;
    #1 chk("flush_ip_inc", 32'(ip_inc), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_count", 32'(q_count), 32'd0);

    // Randomized traffic with flushes, including the FF wrap and 40 targets.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      flush   = ($urandom_range(0, 11) == 0);
      q_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       flush_addr = 8'hFF;
        1:       flush_addr = 8'h40;
        default: flush_addr = 8'($urandom);
      endcase
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a request.
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1 seen = mem_req;
    end
    chk("wait_req", 32'(seen), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_valid", 32'(q_valid), 32'd0);
    chk("rst_count", 32'(q_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Post-reset traffic; the model expects fetch to restart at 00.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      flush      = ($urandom_range(0, 15) == 0);
      q_ready    = ($urandom_range(0, 1) != 0);
      flush_addr = 8'($urandom);
    end
    flush = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
- Instruction prefetch stage sitting directly downstream of the IP register.
- Fetches code bytes from memory at its own fetch pointer, running ahead of IP, and buffers them in a small FIFO for the decoder.
- Pulses ip_inc on every byte consumed; ip_inc drives the IP register's EN, with SEL=0.
- On a control transfer, flush discards queued and in-flight bytes and restarts fetch at flush_addr (the same value loaded into IP with SEL=1).

Parameters:
DEPTH, 4, queue entries; power of two, minimum 2
AW, 8, code address width; matches IP width

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-low reset
flush  input  1  control transfer; discard queue and in-flight fetch
flush_addr  input  AW  new fetch address, sampled when flush=1
mem_req  output  1  memory read request
mem_addr  output  AW  read address; stable while mem_req=1
mem_ack  input  1  read completes this cycle; mem_rdata valid
mem_rdata  input  8  read data
q_valid  output  1  head byte available
q_data  output  8  head byte
q_ready  input  1  decoder accepts head byte
ip_inc  output  1  one-cycle pulse per byte consumed; to IP register EN (SEL=0)
q_count  output  clog2(DEPTH)+1  bytes currently queued

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fetch_addr=0, mem_req=0, mem_addr=0, FIFO empty, q_count=0, q_valid=0, q_data=0, ip_inc=0. Reset mid-request abandons the request; any later mem_ack is ignored until a new request is issued.
- FSM states: IDLE, REQ, DRAIN.
- IDLE:
  - flush=1: fetch_addr<=flush_addr; stay IDLE.
  - else if q_count<DEPTH: mem_addr<=fetch_addr, mem_req<=1, go REQ.
  - else stay IDLE with mem_req=0.
- REQ (mem_req=1, mem_addr held stable):
  - mem_ack=1, flush=0: push mem_rdata; fetch_addr<=fetch_addr+1, wrapping FF->00; mem_req<=0; go IDLE.
  - mem_ack=1, flush=1: drop data; fetch_addr<=flush_addr; mem_req<=0; go IDLE.
  - mem_ack=0, flush=1: fetch_addr<=flush_addr; go DRAIN. mem_req stays 1 and mem_addr stays at the old address; a request is never withdrawn.
  - mem_ack=0, flush=0: stay REQ.
- DRAIN:
  - Hold the request until mem_ack, then drop the data, mem_req<=0, go IDLE.
  - A further flush in DRAIN reloads fetch_addr; state is unchanged.
- At most one outstanding request. Issuing only when q_count<DEPTH guarantees space at ack, so no overflow is possible.
- Output side:
  - q_valid = (q_count!=0).
  - q_data = FIFO head; 0 when empty.
  - pop = q_valid & q_ready & ~flush.
  - ip_inc = pop, registered-free (combinational from the same cycle).
- Push and pop in the same cycle: q_count unchanged, order preserved.
- flush=1: FIFO cleared at the next edge (q_count<=0); any pop or push that cycle is ignored; ip_inc=0.
- Latency: with mem_ack combinational in the first REQ cycle, the byte is visible on q_valid/q_data two edges after leaving IDLE. The fetch bubble is one IDLE cycle per byte.
- Wrap: fetch_addr, and hence mem_addr, increment modulo 2^AW.

Test Plan:
1. Reset release; memory acks 1 cycle after req with rdata=addr^8'hA5; q_ready=0 -> addresses 00,01,02,03 fetched; q_count=4; mem_req stays 0; q_data=A5.
2. From test 1, hold q_ready=1 -> q_data sequence A5,A4,A7,A6,A1...; ip_inc pulses once per byte; mem_addr continues 04,05,... with no gaps or repeats.
3. Request to 05 outstanding (ack delayed 3 cycles); pulse flush with flush_addr=8'h40 -> mem_addr stays 05 until ack; that byte is dropped; q_count=0; next mem_addr=40; first q_data=E5.
4. flush_addr=8'hFF -> fetches FF then 00; q_data 5A then A5.
5. flush and q_valid&q_ready in the same cycle -> ip_inc=0; q_count=0 next cycle.
6. Assert rst low mid-REQ -> mem_req, q_valid and q_count go 0 immediately, without waiting for a clock; after release, the first mem_addr=00.
